// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO PHY-side responder with a 32 x 16 register file.
// Latency: outputs change one clk_i after a detected MDC edge, which is 3-4 clk_i after the pad edge.
// Backpressure: none; the station paces the frame through MDC, and clk_i must run at least 8x MDC.
//
// Ports:
//   clk_i        system clock, rising edge
//   srst_i       synchronous active-high reset
//   mdc_i        asynchronous management clock from the station
//   mdio_i       asynchronous management data from the pad
//   mdio_o       data to drive onto the pad
//   mdio_oen_o   active-low pad output enable (1 = released)
//   reg_wr_o     one-cycle pulse per completed write to a writable register
//   reg_addr_o   register address of that write
//   reg_wdata_o  write data of that write
//
// Build option: define MDIO_PREAMBLE_SUPPRESS_EN to accept a frame after
// any non-empty run of preamble 1s instead of the full 32.

module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1620
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oen_o,
  output logic        reg_wr_o,
  output logic [4:0]  reg_addr_o,
  output logic [15:0] reg_wdata_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA
  } state_t;

  // Synchronizers and MDC edge detection
  logic r_mdc_s1;
  logic r_mdc_s2;
  logic r_mdc_d;
  logic r_mdio_s1;
  logic r_mdio_s2;

  // Frame state
  state_t      r_state;
  logic [5:0]  r_pre_cnt;
  logic [4:0]  r_bit_cnt;
  logic        r_op0;
  logic        r_rd;
  logic        r_addressed;
  logic [4:0]  r_phyad;
  logic [4:0]  r_regad;
  logic [15:0] r_shift;

  // Registered outputs
  logic        r_mdio_o;
  logic        r_mdio_oen;
  logic        r_reg_wr;
  logic [4:0]  r_reg_addr;
  logic [15:0] r_reg_wdata;

  logic [15:0] r_regs [0:31];

  logic        w_mdc_rise;
  logic        w_mdc_fall;
  logic        w_pre_ok;
  logic        w_drive;
  logic        w_reg_ro;
  logic [4:0]  w_phyad_next;
  logic [4:0]  w_regad_next;
  logic [15:0] w_wdata;
  logic [15:0] w_rdata;

  assign w_mdc_rise   = r_mdc_s2 & ~r_mdc_d;
  assign w_mdc_fall   = ~r_mdc_s2 & r_mdc_d;
  assign w_phyad_next = {r_phyad[3:0], r_mdio_s2};
  assign w_regad_next = {r_regad[3:0], r_mdio_s2};
  assign w_wdata      = {r_shift[14:0], r_mdio_s2};
  // Only an addressed read ever turns the pad around.
  assign w_drive      = r_rd & r_addressed;
  assign w_reg_ro     = (r_regad == 5'd2) || (r_regad == 5'd3);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign w_pre_ok = (r_pre_cnt != 6'd0);
`else
  assign w_pre_ok = (r_pre_cnt == 6'd32);
`endif

  // ID registers are constants; everything else comes from the register file.
  always_comb begin
    w_rdata = r_regs[r_regad];
    if (r_regad == 5'd2) begin
      w_rdata = PHY_ID1;
    end else if (r_regad == 5'd3) begin
      w_rdata = PHY_ID2;
    end
  end

  always_ff @(posedge clk_i) begin : p_sync
    if (srst_i) begin
      r_mdc_s1  <= 1'b1;
      r_mdc_s2  <= 1'b1;
      r_mdc_d   <= 1'b1;
      r_mdio_s1 <= 1'b1;
      r_mdio_s2 <= 1'b1;
    end else begin
      r_mdc_s1  <= mdc_i;
      r_mdc_s2  <= r_mdc_s1;
      r_mdc_d   <= r_mdc_s2;
      r_mdio_s1 <= mdio_i;
      r_mdio_s2 <= r_mdio_s1;
    end
  end

  always_ff @(posedge clk_i) begin : p_fsm
    if (srst_i) begin
      r_state     <= S_IDLE;
      r_pre_cnt   <= 6'd0;
      r_bit_cnt   <= 5'd0;
      r_op0       <= 1'b0;
      r_rd        <= 1'b0;
      r_addressed <= 1'b0;
      r_phyad     <= 5'd0;
      r_regad     <= 5'd0;
      r_shift     <= 16'h0000;
      r_mdio_o    <= 1'b1;
      r_mdio_oen  <= 1'b1;
      r_reg_wr    <= 1'b0;
      r_reg_addr  <= 5'd0;
      r_reg_wdata <= 16'h0000;
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 16'h0000;
      end
    end else begin
      r_reg_wr <= 1'b0;

      if (w_mdc_rise) begin
        // Station-driven bits are sampled on MDC rising edges only.
        case (r_state)
          S_IDLE: begin
            if (r_mdio_s2) begin
              if (r_pre_cnt != 6'd32) begin
                r_pre_cnt <= r_pre_cnt + 6'd1;
              end
            end else if (w_pre_ok) begin
              // This 0 is the first start bit.
              r_state   <= S_START;
              r_pre_cnt <= 6'd0;
            end else begin
              r_pre_cnt <= 6'd0;
            end
          end

          S_START: begin
            r_bit_cnt <= 5'd0;
            r_state   <= r_mdio_s2 ? S_OP : S_IDLE;
          end

          S_OP: begin
            if (r_bit_cnt == 5'd0) begin
              r_op0     <= r_mdio_s2;
              r_bit_cnt <= 5'd1;
            end else if (r_op0 != r_mdio_s2) begin
              // 10 = read, 01 = write
              r_rd      <= r_op0;
              r_bit_cnt <= 5'd0;
              r_state   <= S_PHYAD;
            end else begin
              r_state <= S_IDLE;
            end
          end

          S_PHYAD: begin
            r_phyad <= w_phyad_next;
            if (r_bit_cnt == 5'd4) begin
              r_addressed <= (w_phyad_next == PHY_ADDR);
              r_bit_cnt   <= 5'd0;
              r_state     <= S_REGAD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          S_REGAD: begin
            r_regad <= w_regad_next;
            if (r_bit_cnt == 5'd4) begin
              r_bit_cnt <= 5'd0;
              r_state   <= S_TA;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          S_TA: begin
            // TA bit values are never checked; for writes the preload is
            // shifted out by the incoming data anyway.
            if (r_bit_cnt == 5'd0) begin
              r_bit_cnt <= 5'd1;
            end else begin
              r_shift   <= w_rdata;
              r_bit_cnt <= 5'd0;
              r_state   <= S_DATA;
            end
          end

          S_DATA: begin
            if (w_drive) begin
              // Count the station's samples; the falling edge after the
              // 16th one releases the pad.
              if (r_bit_cnt != 5'd16) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end else begin
              // Writes and unaddressed frames shift the pad in for length.
              r_shift <= w_wdata;
              if (r_bit_cnt == 5'd15) begin
                if (!r_rd && r_addressed && !w_reg_ro) begin
                  r_regs[r_regad] <= w_wdata;
                  r_reg_wr        <= 1'b1;
                  r_reg_addr      <= r_regad;
                  r_reg_wdata     <= w_wdata;
                end
                r_bit_cnt <= 5'd0;
                r_pre_cnt <= 6'd0;
                r_state   <= S_IDLE;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end

          default: begin
            r_state   <= S_IDLE;
            r_pre_cnt <= 6'd0;
          end
        endcase
      end else if (w_mdc_fall) begin
        // The pad only changes after MDC falls so the station sees stable
        // data at its rising-edge sample.
        if (r_state == S_TA && w_drive && r_bit_cnt == 5'd1) begin
          r_mdio_o   <= 1'b0;
          r_mdio_oen <= 1'b0;
        end else if (r_state == S_DATA && w_drive) begin
          if (r_bit_cnt == 5'd16) begin
            r_mdio_o   <= 1'b1;
            r_mdio_oen <= 1'b1;
            r_bit_cnt  <= 5'd0;
            r_pre_cnt  <= 6'd0;
            r_state    <= S_IDLE;
          end else begin
            r_mdio_o   <= r_shift[15];
            r_mdio_oen <= 1'b0;
            r_shift    <= {r_shift[14:0], 1'b0};
          end
        end
      end
    end
  end

  assign mdio_o      = r_mdio_o;
  assign mdio_oen_o  = r_mdio_oen;
  assign reg_wr_o    = r_reg_wr;
  assign reg_addr_o  = r_reg_addr;
  assign reg_wdata_o = r_reg_wdata;

endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: directed MDIO station driving read/write frames into mdio_responder.
// Latency: each MDC bit lasts 16 clk cycles; DUT outputs are sampled just before MDC rises.
// Backpressure: none; the bench paces every frame with a fixed number of clock cycles.

module tb_mdio_responder;

  logic        clk = 1'b0;
  logic        srst;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_o;
  logic        mdio_oen_o;
  logic        reg_wr_o;
  logic [4:0]  reg_addr_o;
  logic [15:0] reg_wdata_o;

  always #5 clk = ~clk;

  mdio_responder dut (
    .clk_i       (clk),
    .srst_i      (srst),
    .mdc_i       (mdc),
    .mdio_i      (mdio_in),
    .mdio_o      (mdio_o),
    .mdio_oen_o  (mdio_oen_o),
    .reg_wr_o    (reg_wr_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o)
  );

  // Activity monitor: write pulses, over-long pulses, cycles with the pad driven.
  int          wr_cnt   = 0;
  int          wr_long  = 0;
  int          oen_low  = 0;
  logic        wr_prev  = 1'b0;
  logic [4:0]  last_addr  = 5'd0;
  logic [15:0] last_data  = 16'h0000;

  always @(negedge clk) begin
    if (reg_wr_o) begin
      wr_cnt++;
      last_addr = reg_addr_o;
      last_data = reg_wdata_o;
      if (wr_prev) wr_long++;
    end
    wr_prev = reg_wr_o;
    if (!mdio_oen_o) oen_low++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One MDC period: drive the bit after MDC falls, sample DUT just before MDC rises.
  task automatic mdc_bit(input logic b, output logic so, output logic soen);
    mdc     = 1'b0;
    mdio_in = b;
    repeat (8) @(negedge clk);
    so   = mdio_o;
    soen = mdio_oen_o;
    mdc  = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  logic [15:0] fr_rdat;
  logic        fr_ta1_oen;
  logic        fr_ta2_oen;
  logic        fr_ta2_o;
  logic        fr_end_oen;

  // Leading 0 separates frames so each one depends only on its own preamble.
  task automatic frame(input int pre, input logic rd, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd, input int rst_at);
    logic        so;
    logic        soen;
    logic [15:0] dbits;
    mdc_bit(1'b0, so, soen);
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, so, soen);
    mdc_bit(1'b0, so, soen);
    mdc_bit(1'b1, so, soen);
    mdc_bit(rd, so, soen);
    mdc_bit(!rd, so, soen);
    for (int i = 4; i >= 0; i--) mdc_bit(phy[i], so, soen);
    for (int i = 4; i >= 0; i--) mdc_bit(ra[i], so, soen);
    mdc_bit(1'b1, so, soen);
    fr_ta1_oen = soen;
    mdc_bit(rd ? 1'b1 : 1'b0, so, soen);
    fr_ta2_oen = soen;
    fr_ta2_o   = so;
    dbits = rd ? 16'hFFFF : wd;
    for (int i = 15; i >= 0; i--) begin
      mdc_bit(dbits[i], so, soen);
      fr_rdat[i] = so;
      if (rst_at == i) begin
        chk("rst_pre_oen", mdio_oen_o, 1'b0);
        srst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_oen", mdio_oen_o, 1'b1);
        chk("rst_release_o", mdio_o, 1'b1);
        @(negedge clk);
        srst = 1'b0;
      end
    end
    mdc_bit(1'b1, so, soen);
    fr_end_oen = soen;
  endtask

  int base_wr;
  int base_oen;

  initial begin
    srst    = 1'b1;
    mdc     = 1'b1;
    mdio_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_oen", mdio_oen_o, 1'b1);
    chk("rst_mdio_o", mdio_o, 1'b1);
    chk("rst_wr", reg_wr_o, 1'b0);
    chk("rst_addr", reg_addr_o, 5'd0);
    chk("rst_wdata", reg_wdata_o, 16'h0000);
    srst = 1'b0;
    repeat (4) @(negedge clk);

    // Write 0x1140 to register 0
    base_wr = wr_cnt; base_oen = oen_low;
    frame(32, 1'b0, 5'd1, 5'd0, 16'h1140, -1);
    chk("wr0_pulses", wr_cnt - base_wr, 1);
    chk("wr0_addr", last_addr, 5'd0);
    chk("wr0_data", last_data, 16'h1140);
    chk("wr0_oen_low", oen_low - base_oen, 0);

    // Read register 0 back with turnaround checks
    frame(32, 1'b1, 5'd1, 5'd0, 16'h0000, -1);
    chk("rd0_ta1_oen", fr_ta1_oen, 1'b1);
    chk("rd0_ta2_oen", fr_ta2_oen, 1'b0);
    chk("rd0_ta2_o", fr_ta2_o, 1'b0);
    chk("rd0_data", fr_rdat, 16'h1140);
    chk("rd0_end_oen", fr_end_oen, 1'b1);

    // ID registers
    frame(32, 1'b1, 5'd1, 5'd2, 16'h0000, -1);
    chk("rd2_data", fr_rdat, 16'h0022);
    frame(32, 1'b1, 5'd1, 5'd3, 16'h0000, -1);
    chk("rd3_data", fr_rdat, 16'h1620);

    // Write to read-only register is dropped
    base_wr = wr_cnt;
    frame(32, 1'b0, 5'd1, 5'd2, 16'hFFFF, -1);
    chk("wr2_pulses", wr_cnt - base_wr, 0);
    frame(32, 1'b1, 5'd1, 5'd2, 16'h0000, -1);
    chk("rd2_after_wr", fr_rdat, 16'h0022);

    // Highest register address
    base_wr = wr_cnt;
    frame(32, 1'b0, 5'd1, 5'd31, 16'hA5C3, -1);
    chk("wr31_pulses", wr_cnt - base_wr, 1);
    chk("wr31_addr", last_addr, 5'd31);
    chk("wr31_data", last_data, 16'hA5C3);
    frame(32, 1'b1, 5'd1, 5'd31, 16'h0000, -1);
    chk("rd31_data", fr_rdat, 16'hA5C3);

    // Frame for another PHY is never answered; next valid one is
    base_oen = oen_low; base_wr = wr_cnt;
    frame(32, 1'b1, 5'd5, 5'd0, 16'h0000, -1);
    chk("phy5_oen_low", oen_low - base_oen, 0);
    frame(32, 1'b0, 5'd5, 5'd0, 16'hBEEF, -1);
    chk("phy5_wr_pulses", wr_cnt - base_wr, 0);
    frame(32, 1'b1, 5'd1, 5'd0, 16'h0000, -1);
    chk("rd0_after_phy5", fr_rdat, 16'h1140);

    // Short preamble
    base_oen = oen_low;
    frame(31, 1'b1, 5'd1, 5'd0, 16'h0000, -1);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    chk("pre31_data", fr_rdat, 16'h1140);
`else
    chk("pre31_oen_low", oen_low - base_oen, 0);
`endif

    // Reset during D8 of a read; registers come back cleared
    frame(32, 1'b1, 5'd1, 5'd0, 16'h0000, 8);
    frame(32, 1'b1, 5'd1, 5'd0, 16'h0000, -1);
    chk("rd_after_rst_ta2_oen", fr_ta2_oen, 1'b0);
    chk("rd_after_rst_data", fr_rdat, 16'h0000);
    chk("rd_after_rst_end_oen", fr_end_oen, 1'b1);

    chk("wr_pulse_width", wr_long, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1: PHY address the block answers to.
REQ-002 SHALL have parameter PHY_ID1, default 16'h0022: read-only value of register 2.
REQ-003 SHALL have parameter PHY_ID2, default 16'h1620: read-only value of register 3.
REQ-004 SHALL have port clk_i, input, 1: single system clock; rising edge only.
REQ-005 SHALL have port srst_i, input, 1: reset, synchronous to clk_i, active-high.
REQ-006 SHALL have port mdc_i, input, 1: asynchronous MDIO management clock from the station.
REQ-007 SHALL have port mdio_i, input, 1: asynchronous MDIO data from the pad.
REQ-008 SHALL have port mdio_o, output, 1: MDIO data to drive onto the pad.
REQ-009 SHALL have port mdio_oen_o, output, 1: active-low output enable; 0 drives mdio_o, 1 releases the pad.
REQ-010 SHALL have port reg_wr_o, output, 1: one-cycle pulse on each completed write to a writable register.
REQ-011 SHALL have port reg_addr_o, output, 5: register address of the write; valid while reg_wr_o=1.
REQ-012 SHALL have port reg_wdata_o, output, 16: write data; valid while reg_wr_o=1.

Function
REQ-013 SHALL pass mdc_i and mdio_i through 2-flop synchronizers, then detect MDC rising and falling edges from the synchronized MDC; clk_i SHALL be at least 8x the MDC frequency.
REQ-014 SHALL sample MDIO only on a detected MDC rising edge, and SHALL change mdio_o/mdio_oen_o only on the cycle after a detected MDC falling edge.
REQ-015 SHALL implement a Clause-22 frame FSM with states IDLE, START, OP, PHYAD, REGAD, TA, DATA.
REQ-016 IDLE: SHALL count consecutive sampled 1s, saturating at 32; a sampled 0 with count = 32 SHALL go to START; a sampled 0 with count < 32 SHALL clear the count and stay in IDLE.
REQ-017 START: sampled 1 SHALL go to OP (ST=01); sampled 0 SHALL go to IDLE with the count cleared.
REQ-018 OP: SHALL sample 2 bits; 10 = read, 01 = write; 00 or 11 SHALL abort to IDLE.
REQ-019 PHYAD/REGAD: SHALL each shift in 5 bits, MSB first; the frame is addressed when PHYAD == PHY_ADDR.
REQ-020 TA (read, addressed): during the first TA bit the pad SHALL stay released; at the falling edge after the first TA rising sample, SHALL drive mdio_o=0 with mdio_oen_o=0.
REQ-021 DATA (read, addressed): at each of the next 16 falling edges SHALL drive bits D15..D0 of the selected register; at the falling edge after the D0 rising edge SHALL release (mdio_oen_o=1) and go to IDLE.
REQ-022 TA/DATA (write): SHALL ignore both TA bit values, shift in 16 bits, and after D0 update the register and pulse reg_wr_o for exactly one clk_i cycle.
REQ-023 Register file SHALL hold 32 x 16 bits; registers 2 and 3 SHALL read PHY_ID1/PHY_ID2, and writes to them SHALL be discarded with no reg_wr_o pulse.
REQ-024 Unaddressed frames SHALL track the full 32-bit frame length, never drive the pad, never write, then return to IDLE.
REQ-025 After any frame end or abort, the IDLE 1s count SHALL restart from 0, so the next frame needs a fresh preamble.

Reset
REQ-026 While srst_i=1 the block SHALL hold: state IDLE, preamble count 0, mdio_oen_o=1, mdio_o=1, reg_wr_o=0, reg_addr_o=0, reg_wdata_o=0, synchronizers=1.
REQ-027 Writable registers SHALL reset to 16'h0000.
REQ-028 srst_i asserted mid-frame, including mid-read, SHALL release the pad on the first clk_i edge where srst_i is sampled high.

Configuration
REQ-029 SHALL recognise macro MDIO_PREAMBLE_SUPPRESS_EN.
REQ-030 With MDIO_PREAMBLE_SUPPRESS_EN defined: a 0 sampled in IDLE after at least one 1 SHALL go to START; no 32-bit minimum.
REQ-031 Without MDIO_PREAMBLE_SUPPRESS_EN: IDLE SHALL require 32 consecutive 1s before START, as in REQ-016.

Verification
REQ-032 32x1 preamble, write frame PHYAD=1, REGAD=0, data 16'h1140 -> one reg_wr_o pulse with reg_addr_o=0 and reg_wdata_o=16'h1140; mdio_oen_o=1 throughout.
REQ-033 Read frame of REGAD=0 after REQ-032 -> first TA bit released, second TA bit driven 0, then 16'h1140 MSB first, then released.
REQ-034 Read of REGAD=2 and REGAD=3 -> 16'h0022 and 16'h1620; write 16'hFFFF to REGAD=2 -> no reg_wr_o pulse, and a later read still returns 16'h0022.
REQ-035 Read frame with PHYAD=5 -> mdio_oen_o stays 1 for the entire frame; the following valid frame is answered correctly.
REQ-036 Preamble of 31 ones then frame -> ignored without the macro; answered with MDIO_PREAMBLE_SUPPRESS_EN defined.
REQ-037 srst_i pulsed at data bit D8 of a read -> mdio_oen_o=1 on the next clk_i edge, and the next full frame is answered correctly.
